mm3_argmax_ctrl: RTL and testbench
==================================

Name: mm3_argmax_ctrl

Overview:
Readout sequencer for the final-layer output memory, which holds 32 signed 32-bit logits with a combinational read port. On a start request it walks the read address 0..DEPTH-1 and tracks the running maximum. It then publishes the winning index and value with a one-cycle done pulse. It sits between the final matmul stage and the result display / host readout logic.

Parameters:
DEPTH, 32, number of entries scanned (addresses 0..DEPTH-1); must be 2..65536
DATA_W, 32, width of each signed entry
ADDR_W, 16, width of memory read address
IDX_W, 5, width of reported index; must satisfy 2^IDX_W >= DEPTH

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
start  in  1  request a scan; sampled only in IDLE
abort  in  1  cancel an in-progress scan
rd_addr  out  ADDR_W  read address to the output memory (registered)
rd_data  in  DATA_W  signed data from the memory, combinational on rd_addr
busy  out  1  high while in SCAN
done  out  1  one-cycle pulse when the result is updated
max_idx  out  IDX_W  index of the maximum entry from the last completed scan
max_val  out  DATA_W  signed value of that entry

Behaviour:
- Reset (resetn=0 at a rising edge): state IDLE; rd_addr=0, busy=0, done=0, max_idx=0, max_val=0. Working registers cleared. Reset wins over all other inputs, including mid-scan.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 -> SCAN; rd_addr<=0, busy<=1.
  - start=0 -> stay; rd_addr holds 0.
- SCAN, at each edge with rd_addr=k:
  - Sample rd_data in the same cycle (combinational memory, zero read latency).
  - If k==0: load work_val<=rd_data, work_idx<=0 unconditionally.
  - Else: update when rd_data > work_val, signed compare. Ties keep the earlier index.
  - If k<DEPTH-1: rd_addr<=k+1.
  - If k==DEPTH-1: max_val and max_idx take the final winner (including a same-edge update), state DONE, done<=1, busy<=0, rd_addr<=0.
- DONE: lasts exactly one cycle, then IDLE and done<=0. start during DONE is ignored.
- Latency:
  - start sampled at edge E0; done is high during the cycle after edge E(DEPTH), i.e. DEPTH cycles after start acceptance.
  - The earliest next start is accepted at edge E(DEPTH+2).
- start while busy or in DONE: ignored, not queued.
- abort=1 in SCAN: next edge -> IDLE, busy<=0, rd_addr<=0, no done pulse. max_idx and max_val keep previous results.
- abort=1 on the same edge as k==DEPTH-1: abort wins, no result update.
- abort in IDLE/DONE: no effect. start and abort both high in IDLE: start is ignored.
- max_idx and max_val change only on the done edge; they are stable otherwise.
- rd_addr never exceeds DEPTH-1; no wrap-around within a scan.
- All negative entries are handled correctly: no zero-initialised maximum is used; entry 0 seeds the compare.

Optional Feature:
Macro ARGMAX_TIE_LAST_EN.
- Defined: update on rd_data >= work_val, so ties report the highest index.
- Undefined (default): strict >, so ties report the lowest index.
- No port or timing change either way.

Test Plan:
1. Reset then memory = {0,0,...,0, entry 17 = 100, rest 0}; pulse start -> busy high 32 cycles, done pulse 32 cycles after start edge, max_idx=17, max_val=100.
2. All entries negative, entry i = -1000+i except entry 5 = -3 -> max_idx=5, max_val=-3 (fails if seeded with 0).
3. Entries 4 and 20 both 0x7FFFFFFF, others 0x80000000 -> max_idx=4 by default; max_idx=20 with ARGMAX_TIE_LAST_EN.
4. Complete a scan (idx=17); start a new scan with memory max at 9; assert abort at rd_addr=12 -> no done, busy low next cycle, max_idx stays 17. A fresh start then yields 9.
5. Hold start high continuously -> scans back-to-back with one idle cycle between them: done pulses every 34 cycles, start ignored while busy/DONE.
6. Deassert resetn at rd_addr=20 mid-scan -> next edge all outputs at reset values (max_idx=0, max_val=0, done never pulses).

Source files
------------

// File: rtl/mm3_argmax_ctrl.sv
// Argmax readout sequencer: scans DEPTH signed entries and publishes the winning index/value.
// Define ARGMAX_TIE_LAST_EN to report the highest index on ties (default: lowest index).
module mm3_argmax_ctrl #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IDX_W  = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  max_idx,
    output logic [DATA_W-1:0] max_val
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
    logic signed [DATA_W-1:0]  work_val_q, work_val_d;
    logic [IDX_W-1:0]          work_idx_q, work_idx_d;
    logic signed [DATA_W-1:0]  max_val_q, max_val_d;
    logic [IDX_W-1:0]          max_idx_q, max_idx_d;

    logic                      take;
    logic signed [DATA_W-1:0]  cand_val;
    logic [IDX_W-1:0]          cand_idx;

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        work_val_d = work_val_q;
        work_idx_d = work_idx_q;
        max_val_d  = max_val_q;
        max_idx_d  = max_idx_q;

        // Entry 0 always seeds the running maximum, so all-negative data works.
`ifdef ARGMAX_TIE_LAST_EN
        take = (rd_addr_q == '0) || ($signed(rd_data) >= work_val_q);
`else
        take = (rd_addr_q == '0) || ($signed(rd_data) > work_val_q);
`endif
        cand_val = take ? $signed(rd_data) : work_val_q;
        cand_idx = take ? rd_addr_q[IDX_W-1:0] : work_idx_q;

        unique case (state_q)
            StIdle: begin
                rd_addr_d = '0;
                if (start && !abort) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (abort) begin
                    state_d   = StIdle;
                    rd_addr_d = '0;
                end else begin
                    work_val_d = cand_val;
                    work_idx_d = cand_idx;
                    if (rd_addr_q == LAST_ADDR) begin
                        max_val_d = cand_val;
                        max_idx_d = cand_idx;
                        state_d   = StDone;
                        rd_addr_d = '0;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d   = StIdle;
                rd_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            rd_addr_q  <= '0;
            work_val_q <= '0;
            work_idx_q <= '0;
            max_val_q  <= '0;
            max_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            work_val_q <= work_val_d;
            work_idx_q <= work_idx_d;
            max_val_q  <= max_val_d;
            max_idx_q  <= max_idx_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign busy    = (state_q == StScan);
    assign done    = (state_q == StDone);
    assign max_idx = max_idx_q;
    assign max_val = max_val_q;

endmodule

// File: tb/tb_mm3_argmax_ctrl.sv
// Directed bench for mm3_argmax_ctrl; honours ARGMAX_TIE_LAST_EN for the tie case.
module tb_mm3_argmax_ctrl;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        abort;
    logic [15:0] rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic [4:0]  max_idx;
    logic [31:0] max_val;

    logic [31:0] mem [32];
    int          n_checks;
    int          n_errors;

    mm3_argmax_ctrl #(
        .DEPTH  (32),
        .DATA_W (32),
        .ADDR_W (16),
        .IDX_W  (5)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .abort   (abort),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .max_idx (max_idx),
        .max_val (max_val)
    );

    assign rd_data = (rd_addr < 16'd32) ? mem[rd_addr[4:0]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 32; i++) mem[i] = v;
    endtask

    // Call #1 after an edge with the DUT idle; returns #1 after the edge following done.
    task automatic do_scan(input string tag, input int exp_idx, input logic [31:0] exp_val);
        int   cyc;
        int   busy_cnt;
        logic stable;
        logic [4:0]  prev_idx;
        logic [31:0] prev_val;
        prev_idx = max_idx;
        prev_val = max_val;
        stable   = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cnt++;
            if (max_idx !== prev_idx || max_val !== prev_val) stable = 1'b0;
            tick();
            cyc++;
        end
        check({tag, " done_latency"}, cyc, 32);
        check({tag, " busy_cycles"}, busy_cnt, 32);
        check({tag, " result_stable"}, {31'd0, stable}, 32'd1);
        check({tag, " max_idx"}, {27'd0, max_idx}, exp_idx);
        check({tag, " max_val"}, max_val, exp_val);
        check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        tick();
        check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int done_cnt;
        int done_at [4];
        n_checks = 0;
        n_errors = 0;
        resetn   = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        fill(32'd0);
        tick();
        tick();
        check("rst rd_addr", {16'd0, rd_addr}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst max_idx", {27'd0, max_idx}, 32'd0);
        check("rst max_val", max_val, 32'd0);
        resetn = 1'b1;
        tick();
        tick();
        check("idle rd_addr", {16'd0, rd_addr}, 32'd0);

        // 1: single peak
        fill(32'd0);
        mem[17] = 32'd100;
        do_scan("t1", 17, 32'd100);

        // 2: all negative, seed must come from entry 0
        for (int i = 0; i < 32; i++) mem[i] = 32'(-1000 + i);
        mem[5] = 32'(-3);
        do_scan("t2", 5, 32'hFFFF_FFFD);

        // 3: tie between extremes
        fill(32'h8000_0000);
        mem[4]  = 32'h7FFF_FFFF;
        mem[20] = 32'h7FFF_FFFF;
`ifdef ARGMAX_TIE_LAST_EN
        do_scan("t3", 20, 32'h7FFF_FFFF);
`else
        do_scan("t3", 4, 32'h7FFF_FFFF);
`endif

        // 4: abort keeps old result
        fill(32'd0);
        mem[17] = 32'd100;
        do_scan("t4a", 17, 32'd100);
        fill(32'd0);
        mem[9] = 32'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (rd_addr != 16'd12 && n < 50) begin
            tick();
            n++;
        end
        check("t4 reach_addr12", {16'd0, rd_addr}, 32'd12);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4 busy_after_abort", {31'd0, busy}, 32'd0);
        check("t4 rd_addr_after_abort", {16'd0, rd_addr}, 32'd0);
        check("t4 max_idx_kept", {27'd0, max_idx}, 32'd17);
        check("t4 max_val_kept", max_val, 32'd100);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("t4 no_done_after_abort", done_cnt, 32'd0);
        do_scan("t4b", 9, 32'd50);

        // 5: start held high, one scan every 34 cycles
        start    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) done_at[i] = -1;
        for (int c = 1; c <= 110; c++) begin
            tick();
            if (done) begin
                if (done_cnt < 4) done_at[done_cnt] = c;
                done_cnt++;
            end
        end
        start = 1'b0;
        check("t5 done_count", done_cnt, 32'd3);
        check("t5 done_first", done_at[0], 32'd33);
        check("t5 done_second", done_at[1], 32'd67);
        check("t5 done_third", done_at[2], 32'd101);
        check("t5 max_idx", {27'd0, max_idx}, 32'd9);
        for (int i = 0; i < 40; i++) tick();
        check("t5 idle_after", {31'd0, busy}, 32'd0);

        // 6: reset mid-scan
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (rd_addr != 16'd20 && n < 50) begin
            tick();
            n++;
        end
        check("t6 reach_addr20", {16'd0, rd_addr}, 32'd20);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("t6 rd_addr", {16'd0, rd_addr}, 32'd0);
        check("t6 busy", {31'd0, busy}, 32'd0);
        check("t6 done", {31'd0, done}, 32'd0);
        check("t6 max_idx", {27'd0, max_idx}, 32'd0);
        check("t6 max_val", max_val, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) done_cnt++;
            tick();
        end
        check("t6 stays_idle", done_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
